// File: rtl/cmp_rr_arbiter.sv
// cmp_rr_arbiter
// Round-robin arbiter/sequencer sharing a single unsigned magnitude comparator
// (alb/aeb/agb) among NREQ requesters. One requester is granted at a time.
// Its operands are latched, compared one cycle later, and the registered flags
// are returned with the requester index.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   req     request lines, bit i = requester i
//   a_in    packed A operands, requester i at [i*WIDTH +: WIDTH]
//   b_in    packed B operands, same packing
//   gnt     one-hot grant, high for exactly one cycle
//   busy    high while a comparison is in flight (state != IDLE)
//   done    one-cycle pulse, flags and res_id valid
//   res_id  index of the most recently granted requester
//   alb/aeb/agb  registered A<B / A==B / A>B; held until the next compare
module cmp_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        res_id,
  output logic                  alb,
  output logic                  aeb,
  output logic                  agb
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t state, nxt;

  logic [NREQ-1:0][WIDTH-1:0] a_v, b_v;
  logic [WIDTH-1:0]           opa, opb;
  logic [IDW-1:0]             ptr, win;
  logic                       any;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_v[gi] = a_in[gi*WIDTH +: WIDTH];
      assign b_v[gi] = b_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Rotating priority: scan from ptr+1 upward, wrapping at NREQ, so the last
  // winner becomes lowest priority on the next arbitration.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any) nxt = CMP;
      CMP:     nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= '0;
      done   <= 1'b0;
      res_id <= '0;
      alb    <= 1'b0;
      aeb    <= 1'b0;
      agb    <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      ptr    <= IDW'(NREQ-1);
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            gnt    <= NREQ'(1) << win;
            res_id <= win;
            ptr    <= win;
            opa    <= a_v[win];
            opb    <= b_v[win];
          end else begin
            gnt <= '0;
          end
        end
        CMP: begin
          // Compare the latched copy so late operand changes cannot leak in.
          gnt  <= '0;
          alb  <= (opa <  opb);
          aeb  <= (opa == opb);
          agb  <= (opa >  opb);
          done <= 1'b1;
        end
        RESP: done <= 1'b0;
        default: begin
          gnt  <= '0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Randomized + directed bench for cmp_rr_arbiter with a scoreboard queue.
module tb_cmp_rr_arbiter;
  localparam int NREQ = 4, WIDTH = 4, IDW = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in, b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy, done, alb, aeb, agb;
  logic [IDW-1:0]        res_id;

  always #5 clk = ~clk;

  cmp_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .done(done), .res_id(res_id),
    .alb(alb), .aeb(aeb), .agb(agb)
  );

  typedef struct { int id; bit lt; bit eq; bit gt; } res_t;

  res_t sbq[$];
  int   gnt_log[$];
  int   checks = 0, failures = 0;

  // Reference model state: who won last, cycles left before the shared
  // comparator is free again, and what the outputs should show.
  int              last_w = NREQ-1;
  int              cool = 0;
  int              exp_id = 0;
  logic [NREQ-1:0] exp_gnt = '0;
  bit              exp_done = 0;
  res_t            held = '{0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: on each edge, if the comparator is free and someone requests,
  // the first requester after the last winner (wrapping) wins; its result
  // is plain arithmetic on its operands at that moment.
  always @(posedge clk) begin
    if (rst) begin
      last_w = NREQ-1; cool = 0; exp_id = 0; exp_gnt = '0; exp_done = 0;
      sbq.delete();
    end else begin
      exp_done = (cool == 2);
      exp_gnt  = '0;
      if (cool == 0 && req != '0) begin
        int w, a, b;
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(last_w + k) % NREQ]) w = (last_w + k) % NREQ;
        a = int'(a_in[w*WIDTH +: WIDTH]);
        b = int'(b_in[w*WIDTH +: WIDTH]);
        exp_gnt = NREQ'(1) << w;
        last_w  = w;
        exp_id  = w;
        sbq.push_back('{w, a < b, a == b, a > b});
        cool = 2;
      end else if (cool > 0) begin
        cool--;
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_gnt", int'(gnt), 0);
      chk("reset_busy_done", int'({busy, done}), 0);
      chk("reset_res_id", int'(res_id), 0);
      chk("reset_flags", int'({alb, aeb, agb}), 0);
      held = '{0, 0, 0, 0};
    end else begin
      chk("gnt", int'(gnt), int'(exp_gnt));
      chk("busy", int'(busy), int'(cool != 0));
      chk("done", int'(done), int'(exp_done));
      chk("res_id", int'(res_id), exp_id);
      if (gnt != '0) begin
        int g;
        g = -1;
        for (int i = 0; i < NREQ; i++) if (gnt == NREQ'(1) << i) g = i;
        gnt_log.push_back(g);
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("done_without_grant", 1, 0);
        end else begin
          res_t r;
          r = sbq.pop_front();
          chk("result_id", int'(res_id), r.id);
          chk("result_flags", int'({alb, aeb, agb}), int'({r.lt, r.eq, r.gt}));
          held = r;
        end
      end else begin
        chk("flags_hold", int'({alb, aeb, agb}), int'({held.lt, held.eq, held.gt}));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic setop(input int i, input int a, input int b);
    a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
    b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic chk_log(input string name, input int e0, input int e1,
                         input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk(name, (gnt_log.size() > i) ? gnt_log[i] : -1, e[i]);
  endtask

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Single requester, A<B
    setop(0, 10, 12); req = 4'b0001; tick(1); req = '0; tick(4);

    // A>B boundary, then A==B; flags hold between the dones
    setop(2, 15, 0); req = 4'b0100; tick(1); req = '0; tick(3);
    setop(3, 10, 10); req = 4'b1000; tick(1); req = '0; tick(4);

    // All four requesting: rotate 0,1,2,3
    setop(0, 0, 0); setop(1, 0, 15); setop(2, 7, 3); setop(3, 5, 9);
    gnt_log.delete(); req = 4'b1111; tick(12); req = '0; tick(3);
    chk_log("order_all", 0, 1, 2, 3);

    // Fairness between 0 and 3
    gnt_log.delete(); req = 4'b1001; tick(12); req = '0; tick(3);
    chk_log("order_fair", 0, 3, 0, 3);

    // Operand changed after grant must not affect the result
    setop(1, 3, 9); req = 4'b0010; tick(1); setop(1, 12, 9); req = '0; tick(4);

    // Reset during CMP: abort, no done, pointer back to NREQ-1
    setop(0, 4, 4); req = 4'b0001; tick(1); req = '0;
    chk("busy_before_abort", int'(busy), 1);
    rst = 1'b1; #1;
    chk("abort_outputs", int'({gnt, busy, done}), 0);
    tick(2); rst = 1'b0;
    gnt_log.delete(); req = 4'b1111; tick(2); req = '0;
    chk("first_after_reset", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    tick(4);

    // Random traffic, including boundary operands and occasional resets
    for (int c = 0; c < 600; c++) begin
      req = NREQ'($urandom_range(0, 15)) & NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        int a, b;
        a = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 15 : 0) : $urandom_range(0, 15);
        b = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 15 : 0) : $urandom_range(0, 15);
        setop(i, a, b);
      end
      rst = ($urandom_range(0, 99) == 0);
      tick(1);
      rst = 1'b0;
    end
    req = '0;
    tick(5);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
